// File: rtl/stage_memory_pkg.sv
// Shared definitions for the Osiris I memory stage: funct3 codes, WB select codes,
// access FSM states and the illegal-funct3 predicate.
package stage_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic f3_illegal(input logic [2:0] funct3);
        return funct3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/stage_memory_load_store_align.sv
// Byte-lane steering for stores and lane selection / extension for loads,
// plus detection of misaligned or illegal-size accesses.
module load_store_align
    import stage_memory_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr, 3'b000} +: 8];
    assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        be         = 4'b0000;
        lane_wdata = wdata;
        load_data  = rdata;
        misaligned = f3_illegal(funct3);

        // Store steering follows the access size held in funct3[1:0].
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = misaligned | addr[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = misaligned | (addr != 2'b00);
            end
            default: ;
        endcase

        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {24'h000000, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {16'h0000, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Osiris I memory stage: EX/M pipeline register, req/ack data-memory access FSM with
// timeout abort, and the M-side forwarding / write-back outputs.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   i_alu_result_EX,
    input  logic [DATA_WIDTH-1:0]   i_write_data_EX,
    input  logic [DATA_WIDTH-1:0]   i_pc_plus4_EX,
    input  logic [REG_ADDR_W-1:0]   i_rd_EX,
    input  logic [2:0]              i_funct3_EX,
    input  logic                    i_mem_read_EX,
    input  logic                    i_mem_write_EX,
    input  logic                    i_reg_write_EX,
    input  logic [1:0]              i_result_src_EX,
    output logic                    o_dmem_req,
    output logic                    o_dmem_we,
    output logic [DATA_WIDTH-1:0]   o_dmem_addr,
    output logic [DATA_WIDTH/8-1:0] o_dmem_be,
    output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
    input  logic                    i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]   i_dmem_rdata,
    output logic [DATA_WIDTH-1:0]   o_alu_result_M,
    output logic [DATA_WIDTH-1:0]   o_read_data_M,
    output logic [DATA_WIDTH-1:0]   o_pc_plus4_M,
    output logic [REG_ADDR_W-1:0]   o_rd_M,
    output logic                    o_reg_write_M,
    output logic [1:0]              o_result_src_M,
    output logic                    o_stall_M,
    output logic                    o_misaligned_M,
    output logic                    o_bus_err_M
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] pc4;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            result_src;
    } exm_t;

    exm_t       exm_q;
    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;

    logic                    access, access_valid, timeout, req;
    logic                    misaligned;
    logic [DATA_WIDTH/8-1:0] lane_be;
    logic [DATA_WIDTH-1:0]   lane_wdata, load_data;

    load_store_align u_align (
        .addr       (exm_q.alu[1:0]),
        .funct3     (exm_q.funct3),
        .wdata      (exm_q.wdata),
        .rdata      (i_dmem_rdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exm_q <= '0;
        end else if (!o_stall_M) begin
            exm_q <= '{alu:        i_alu_result_EX,
                       wdata:      i_write_data_EX,
                       pc4:        i_pc_plus4_EX,
                       rd:         i_rd_EX,
                       funct3:     i_funct3_EX,
                       mem_read:   i_mem_read_EX,
                       mem_write:  i_mem_write_EX,
                       reg_write:  i_reg_write_EX,
                       result_src: i_result_src_EX};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign access       = exm_q.mem_read | exm_q.mem_write;
    assign access_valid = access & ~misaligned;

    // timer_q counts cycles already stalled; an ack in the limit cycle still wins.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_valid && !i_dmem_ack) begin
                    state_d = ST_WAIT;
                    timer_d = 8'd1;
                end
            end
            ST_WAIT: begin
                if (i_dmem_ack) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q >= TIMEOUT_LIM) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign req = access_valid & ~timeout;

    assign o_dmem_req   = req;
    assign o_dmem_we    = req & exm_q.mem_write;
    assign o_dmem_addr  = req ? {exm_q.alu[DATA_WIDTH-1:2], 2'b00} : '0;
    assign o_dmem_be    = (req & exm_q.mem_write) ? lane_be : '0;
    assign o_dmem_wdata = (req & exm_q.mem_write) ? lane_wdata : '0;

    assign o_stall_M      = req & ~i_dmem_ack;
    assign o_read_data_M  = (req & i_dmem_ack & exm_q.mem_read) ? load_data : '0;
    assign o_misaligned_M = access & misaligned;
    assign o_bus_err_M    = timeout;
    assign o_reg_write_M  = exm_q.reg_write & ~o_misaligned_M & ~timeout;

    assign o_alu_result_M = exm_q.alu;
    assign o_pc_plus4_M   = exm_q.pc4;
    assign o_rd_M         = exm_q.rd;
    assign o_result_src_M = exm_q.result_src;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed scenarios plus randomized access
// streams compared against an arithmetic reference model of the memory stage.
module tb_stage_memory;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_alu_result_EX, i_write_data_EX, i_pc_plus4_EX;
    logic [4:0]  i_rd_EX;
    logic [2:0]  i_funct3_EX;
    logic        i_mem_read_EX, i_mem_write_EX, i_reg_write_EX;
    logic [1:0]  i_result_src_EX;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_alu_result_M, o_read_data_M, o_pc_plus4_M;
    logic [4:0]  o_rd_M;
    logic        o_reg_write_M;
    logic [1:0]  o_result_src_M;
    logic        o_stall_M, o_misaligned_M, o_bus_err_M;

    int checks = 0;
    int errors = 0;

    stage_memory #(.DATA_WIDTH(32), .REG_ADDR_W(5), .TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_alu_result_EX(i_alu_result_EX), .i_write_data_EX(i_write_data_EX),
        .i_pc_plus4_EX(i_pc_plus4_EX), .i_rd_EX(i_rd_EX), .i_funct3_EX(i_funct3_EX),
        .i_mem_read_EX(i_mem_read_EX), .i_mem_write_EX(i_mem_write_EX),
        .i_reg_write_EX(i_reg_write_EX), .i_result_src_EX(i_result_src_EX),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_alu_result_M(o_alu_result_M), .o_read_data_M(o_read_data_M),
        .o_pc_plus4_M(o_pc_plus4_M), .o_rd_M(o_rd_M), .o_reg_write_M(o_reg_write_M),
        .o_result_src_M(o_result_src_M), .o_stall_M(o_stall_M),
        .o_misaligned_M(o_misaligned_M), .o_bus_err_M(o_bus_err_M)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] alu, wd, pc4, rdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        ld, st, rw;
        logic [1:0]  rs;
        int          wait_c;   // M cycle index carrying the ack; beyond TO means never
    } op_t;

    // ---------------- reference model ----------------
    function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] addr);
        int size = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return (addr % size) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {24'h0, wd[7:0]} * 32'h0101_0101;
            2'd1:    return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] raw);
        logic [31:0] v;
        v = raw >> (8 * (addr % 4));
        case (f3[1:0])
            2'd0: begin
                v = v & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = v & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic op_t zero_op();
        op_t o;
        o = '{alu: 0, wd: 0, pc4: 0, rdata: 0, rd: 0, f3: 0, ld: 0, st: 0, rw: 0, rs: 0,
              wait_c: 99};
        return o;
    endfunction

    function automatic op_t bubble(input int wait_c);
        op_t o;
        o = zero_op();
        o.alu = $urandom; o.wd = $urandom; o.pc4 = $urandom;
        o.rd = 5'($urandom); o.rs = 2'($urandom_range(0, 2));
        o.rw = 1'($urandom_range(0, 1));
        o.wait_c = wait_c;
        return o;
    endfunction

    function automatic op_t mem_op(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdata, input int wait_c);
        op_t o;
        o = bubble(wait_c);
        o.ld = ld; o.st = st; o.f3 = f3; o.alu = addr; o.wd = wd; o.rdata = rdata;
        o.rw = ld; o.rs = ld ? 2'b01 : 2'b00;
        return o;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_ex(input op_t o);
        i_alu_result_EX = o.alu;  i_write_data_EX = o.wd;  i_pc_plus4_EX = o.pc4;
        i_rd_EX = o.rd;  i_funct3_EX = o.f3;  i_mem_read_EX = o.ld;
        i_mem_write_EX = o.st;  i_reg_write_EX = o.rw;  i_result_src_EX = o.rs;
    endtask

    // cur sits in M on entry (posedge+1); nxt waits in EX and must only enter once M frees up.
    task automatic m_phase(input op_t cur, input op_t nxt, input string tag);
        logic access, valid, e_mis, ackc, to, e_req, e_stall, e_rw, done;
        logic [31:0] e_addr, e_wdata, e_read;
        logic [3:0]  e_be;
        int c;
        drive_ex(nxt);
        access = cur.ld || cur.st;
        e_mis  = access && exp_mis(cur.f3, cur.alu);
        valid  = access && !e_mis;
        c = 0;
        done = 1'b0;
        while (!done) begin
            ackc = (c == cur.wait_c);
            to   = valid && !ackc && (c == TO);
            i_dmem_ack   = ackc;
            i_dmem_rdata = ackc ? cur.rdata : $urandom;
            e_req   = valid && !to;
            e_stall = e_req && !ackc;
            e_addr  = e_req ? (cur.alu & ~32'h3) : 32'h0;
            e_be    = (e_req && cur.st) ? exp_be(cur.f3, cur.alu) : 4'h0;
            e_wdata = (e_req && cur.st) ? exp_wdata(cur.f3, cur.wd) : 32'h0;
            e_read  = (e_req && ackc && cur.ld) ? exp_load(cur.f3, cur.alu, cur.rdata) : 32'h0;
            e_rw    = cur.rw && !e_mis && !to;
            @(negedge i_clk);
            checks++;
            if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata} !==
                {e_req, e_req && cur.st, e_addr, e_be, e_wdata}) begin
                errors++;
                $display("FAIL %s bus c%0d: got req/we/addr/be/wdata %b %b %h %h %h exp %b %b %h %h %h",
                         tag, c, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
                         e_req, e_req && cur.st, e_addr, e_be, e_wdata);
            end
            checks++;
            if ({o_stall_M, o_misaligned_M, o_bus_err_M, o_reg_write_M} !==
                {e_stall, e_mis, to, e_rw}) begin
                errors++;
                $display("FAIL %s flags c%0d: got stall/mis/berr/rw %b exp %b", tag, c,
                         {o_stall_M, o_misaligned_M, o_bus_err_M, o_reg_write_M},
                         {e_stall, e_mis, to, e_rw});
            end
            checks++;
            if ({o_alu_result_M, o_pc_plus4_M, o_rd_M, o_result_src_M} !==
                {cur.alu, cur.pc4, cur.rd, cur.rs}) begin
                errors++;
                $display("FAIL %s exm_regs c%0d: got %h %h %h %h exp %h %h %h %h", tag, c,
                         o_alu_result_M, o_pc_plus4_M, o_rd_M, o_result_src_M,
                         cur.alu, cur.pc4, cur.rd, cur.rs);
            end
            checks++;
            if (o_read_data_M !== e_read) begin
                errors++;
                $display("FAIL %s read_data c%0d: got %h exp %h", tag, c, o_read_data_M, e_read);
            end
            done = !valid || ackc || to;
            @(posedge i_clk); #1;
            c++;
        end
        i_dmem_ack = 1'b0;
    endtask

    task automatic run_ops(input op_t q[$], input string tag);
        drive_ex(q[0]);
        @(posedge i_clk); #1;
        for (int i = 0; i < q.size(); i++)
            m_phase(q[i], (i + 1 < q.size()) ? q[i + 1] : zero_op(), tag);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata, o_alu_result_M,
             o_read_data_M, o_pc_plus4_M, o_rd_M, o_reg_write_M, o_result_src_M, o_stall_M,
             o_misaligned_M, o_bus_err_M} !== '0) begin
            errors++;
            $display("FAIL %s all_outputs_zero: got req=%b stall=%b addr=%h alu=%h rd=%h rw=%b exp all 0",
                     tag, o_dmem_req, o_dmem_stall_probe(), o_dmem_addr, o_alu_result_M, o_rd_M,
                     o_reg_write_M);
        end
    endtask

    function automatic logic o_dmem_stall_probe();
        return o_stall_M;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        drive_ex(zero_op());
        i_dmem_ack = 1'b0;
        i_dmem_rdata = 32'h0;
        #12;
        check_all_zero("reset_active");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all_zero("reset_released");
        @(posedge i_clk); #1;
    endtask

    task automatic test_zero_wait_lw();
        op_t q[$];
        q.push_back(mem_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0));
        run_ops(q, "zero_wait_lw");
    endtask

    task automatic test_lb_wait();
        op_t q[$];
        q.push_back(mem_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 3));
        run_ops(q, "lb_sign_wait3");
    endtask

    task automatic test_sh_lhu();
        op_t q[$];
        q.push_back(mem_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 1));
        q.push_back(bubble(99));
        q.push_back(mem_op(1, 0, 3'b101, 32'h202, 32'h0, 32'hABCD_0000, 0));
        run_ops(q, "sh_lhu");
    endtask

    task automatic test_misaligned();
        op_t q[$];
        q.push_back(mem_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h5555_AAAA, 0));
        q.push_back(mem_op(0, 1, 3'b001, 32'h203, 32'hFFFF_FFFF, 32'h0, 99));
        q.push_back(mem_op(1, 0, 3'b110, 32'h300, 32'h0, 32'h0, 0));
        q.push_back(mem_op(1, 0, 3'b100, 32'h303, 32'h0, 32'h7F00_0000, 2));
        run_ops(q, "misaligned");
    endtask

    task automatic test_timeout();
        op_t q[$];
        q.push_back(mem_op(1, 0, 3'b010, 32'h400, 32'h0, 32'h1357_9BDF, 99));
        q.push_back(bubble(0));   // late ack while idle with nothing outstanding
        q.push_back(mem_op(0, 1, 3'b010, 32'h404, 32'hCAFE_F00D, 32'h0, TO));
        q.push_back(mem_op(0, 1, 3'b000, 32'h405, 32'h0000_00A5, 32'h0, 99));
        run_ops(q, "timeout");
    endtask

    task automatic test_back_to_back();
        op_t q[$];
        q.push_back(mem_op(0, 1, 3'b010, 32'h500, 32'h0102_0304, 32'h0, 2));
        q.push_back(mem_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h0102_0304, 0));
        q.push_back(mem_op(0, 1, 3'b000, 32'h502, 32'h0000_0077, 32'h0, 0));
        q.push_back(mem_op(1, 0, 3'b100, 32'h501, 32'h0, 32'hFFFF_88FF, 1));
        q.push_back(mem_op(1, 0, 3'b001, 32'h502, 32'h0, 32'h8001_0000, 3));
        run_ops(q, "back_to_back");
    endtask

    task automatic test_random();
        op_t q[$];
        logic [2:0] f3_tab[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 9);
            logic [2:0] f3 = ($urandom_range(0, 9) == 0) ? f3_tab[$urandom_range(5, 7)]
                                                         : f3_tab[$urandom_range(0, 4)];
            logic [31:0] addr = {$urandom_range(0, 32'h3FFF), 2'b00} |
                                (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            int w = $urandom_range(0, TO + 2);
            if (kind < 2)       q.push_back(bubble(w));
            else if (kind < 6)  q.push_back(mem_op(1, 0, f3, addr, 32'h0, $urandom, w));
            else                q.push_back(mem_op(0, 1, {1'b0, f3[1:0]}, addr, $urandom, 32'h0, w));
        end
        run_ops(q, "random");
    endtask

    task automatic test_reset_mid_wait();
        op_t q[$];
        drive_ex(mem_op(1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 99));
        @(posedge i_clk); #1;
        drive_ex(zero_op());
        i_dmem_ack = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_dmem_req, o_stall_M} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_wait pre_reset: got req/stall %b exp 11", {o_dmem_req, o_stall_M});
        end
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_wait_async");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all_zero("rst_mid_wait_released");
        @(posedge i_clk); #1;
        q.push_back(mem_op(1, 0, 3'b010, 32'h700, 32'h0, 32'h2468_ACE0, 3));
        q.push_back(mem_op(1, 0, 3'b001, 32'h702, 32'h0, 32'h9ABC_0000, 99));
        run_ops(q, "post_reset");
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_lb_wait();
        test_sh_lhu();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
